// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master (fetch/data) to one-slave bus arbiter with timeout and fetch flush; ARB_ROUND_ROBIN_EN selects round-robin arbitration
module bus_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic        i_err,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_sel,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic        s_cyc,
   output logic        s_we,
   output logic [3:0]  s_sel,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic        s_ack,
   input  logic [31:0] s_rdata,
   input  logic        flush_i,
   output logic        stallreq_if_o,
   output logic        stallreq_mem_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   wait_q, wait_d;
   logic               s_cyc_q, s_cyc_d;
   logic               s_we_q, s_we_d;
   logic [3:0]         s_sel_q, s_sel_d;
   logic [31:0]        s_addr_q, s_addr_d;
   logic [31:0]        s_wdata_q, s_wdata_d;
   logic               i_ack_q, i_ack_d;
   logic               i_err_q, i_err_d;
   logic               d_ack_q, d_ack_d;
   logic               d_err_q, d_err_d;
   logic [31:0]        i_rdata_q, i_rdata_d;
   logic [31:0]        d_rdata_q, d_rdata_d;
   logic               flush_q, flush_d;
   logic               pick_d;
   logic               squash;
`ifdef ARB_ROUND_ROBIN_EN
   logic               last_d_q, last_d_d;
`endif

   // Winner selection: data wins ties unless round-robin says fetch is due
`ifdef ARB_ROUND_ROBIN_EN
   assign pick_d = d_req & (~i_req | ~last_d_q);
`else
   assign pick_d = d_req;
`endif

   // State register and all datapath registers; reset drops the bus immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         wait_q    <= '0;
         s_cyc_q   <= 1'b0;
         s_we_q    <= 1'b0;
         s_sel_q   <= 4'b0000;
         s_addr_q  <= 32'h0;
         s_wdata_q <= 32'h0;
         i_ack_q   <= 1'b0;
         i_err_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         d_err_q   <= 1'b0;
         i_rdata_q <= 32'h0;
         d_rdata_q <= 32'h0;
         flush_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q  <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         s_cyc_q   <= s_cyc_d;
         s_we_q    <= s_we_d;
         s_sel_q   <= s_sel_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         i_ack_q   <= i_ack_d;
         i_err_q   <= i_err_d;
         d_ack_q   <= d_ack_d;
         d_err_q   <= d_err_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         flush_q   <= flush_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q  <= last_d_d;
`endif
      end
   end

   // Next-state: arbitrate in IDLE, wait for ack or timeout in BUSY_*, one-cycle response in RESP
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      s_cyc_d   = s_cyc_q;
      s_we_d    = s_we_q;
      s_sel_d   = s_sel_q;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      i_ack_d   = 1'b0;
      i_err_d   = 1'b0;
      d_ack_d   = 1'b0;
      d_err_d   = 1'b0;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      flush_d   = flush_q;
      squash    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_d  = last_d_q;
`endif
      case (state_q)
         IDLE: begin
            if (i_req | d_req) begin
               s_cyc_d = 1'b1;
               wait_d  = '0;
               flush_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
               last_d_d = pick_d;
`endif
               if (pick_d) begin
                  s_we_d    = d_we;
                  s_sel_d   = d_sel;
                  s_addr_d  = d_addr;
                  s_wdata_d = d_wdata;
                  state_d   = BUSY_D;
               end else begin
                  s_we_d    = 1'b0;
                  s_sel_d   = 4'b1111;
                  s_addr_d  = i_addr;
                  s_wdata_d = 32'h0;
                  state_d   = BUSY_I;
               end
            end
         end
         BUSY_I, BUSY_D: begin
            // A flush seen in any fetch-busy cycle squashes that fetch's response
            if (state_q == BUSY_I) begin
               squash = flush_q | flush_i;
               if (flush_i) flush_d = 1'b1;
            end
            if (s_ack) begin
               s_cyc_d = 1'b0;
               state_d = RESP;
               if (state_q == BUSY_D) begin
                  d_ack_d   = 1'b1;
                  d_rdata_d = s_rdata;
               end else if (!squash) begin
                  i_ack_d   = 1'b1;
                  i_rdata_d = s_rdata;
               end
            end else begin
               wait_d = wait_q + CNT_W'(1);
               if (wait_q == CNT_W'(TIMEOUT - 1)) begin
                  s_cyc_d = 1'b0;
                  state_d = RESP;
                  if (state_q == BUSY_D) begin
                     d_err_d   = 1'b1;
                     d_rdata_d = 32'h0;
                  end else if (!squash) begin
                     i_err_d   = 1'b1;
                     i_rdata_d = 32'h0;
                  end
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign s_cyc          = s_cyc_q;
   assign s_we           = s_we_q;
   assign s_sel          = s_sel_q;
   assign s_addr         = s_addr_q;
   assign s_wdata        = s_wdata_q;
   assign i_ack          = i_ack_q;
   assign i_err          = i_err_q;
   assign d_ack          = d_ack_q;
   assign d_err          = d_err_q;
   assign i_rdata        = i_rdata_q;
   assign d_rdata        = d_rdata_q;
   assign stallreq_if_o  = i_req & ~i_ack_q;
   assign stallreq_mem_o = d_req & ~d_ack_q;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum number of s_cyc cycles a transfer may wait for s_ack before it is aborted.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port i_req / i_addr, input, 1 / 32: instruction-fetch read request and its address.
REQ-005 SHALL have port i_ack / i_err / i_rdata, output, 1 / 1 / 32: fetch completion pulse, abort pulse, and read data.
REQ-006 SHALL have port d_req / d_we / d_sel / d_addr / d_wdata, input, 1 / 1 / 4 / 32 / 32: data-access request, write enable, byte select, address, and write data.
REQ-007 SHALL have port d_ack / d_err / d_rdata, output, 1 / 1 / 32: data completion pulse, abort pulse, and read data.
REQ-008 SHALL have port s_cyc / s_we / s_sel / s_addr / s_wdata, output, 1 / 1 / 4 / 32 / 32: unified memory port request.
REQ-009 SHALL have port s_ack / s_rdata, input, 1 / 32: memory completion and read data.
REQ-010 SHALL have port flush_i, input, 1: pipeline flush; squashes the in-flight fetch response.
REQ-011 SHALL have port stallreq_if_o / stallreq_mem_o, output, 1 / 1: stall requests to the pipeline controller.

Function
REQ-012 SHALL implement the states IDLE, BUSY_I, BUSY_D and RESP.
REQ-013 SHALL arbitrate in IDLE: if any request is pending, it SHALL latch the winner's addr, we, sel and wdata into the s_* registers, assert s_cyc on the next cycle, and enter BUSY_I or BUSY_D.
REQ-014 SHALL drive fetch transfers with s_we=0 and s_sel=4'b1111.
REQ-015 SHALL hold s_cyc and all s_* outputs stable in BUSY_* until s_ack=1 or the timeout fires.
REQ-016 SHALL, on s_ack in BUSY_*, deassert s_cyc at the next edge, register s_rdata into the owner's rdata, pulse the owner's ack for exactly one cycle in RESP, and then return to IDLE.
REQ-017 SHALL give a minimum latency of 2 cycles from the req edge to the ack cycle: req seen at cycle 0, s_cyc at cycle 1, s_ack at cycle 1, ack at cycle 2.
REQ-018 SHALL require the master to hold req and its signals stable until ack or err, and to drop req or present a new request in the cycle after the pulse; a req still high in IDLE is treated as a new transfer.
REQ-019 SHALL keep a wait counter that clears on entry to BUSY_* and increments each BUSY_* cycle without s_ack.
REQ-020 SHALL, when the wait counter reaches TIMEOUT, drop s_cyc, pulse the owner's err for one cycle in RESP (never ack), and set the owner's rdata to 0.
REQ-021 SHALL treat s_ack arriving in the same cycle as the timeout as a normal completion (ack wins).
REQ-022 SHALL, when flush_i=1 in any cycle of BUSY_I or on entry to RESP for a fetch, complete the slave transfer but suppress i_ack/i_err; i_rdata SHALL be unchanged.
REQ-023 SHALL ignore flush_i for data transfers and in IDLE.
REQ-024 SHALL drive stallreq_if_o = i_req & ~i_ack and stallreq_mem_o = d_req & ~d_ack, combinationally.
REQ-025 SHALL ignore s_ack outside BUSY_*.

Reset
REQ-026 SHALL, while rst=0, asynchronously force state IDLE, wait counter 0, s_cyc/s_we=0, s_sel=0, s_addr/s_wdata=0, i_ack/i_err/d_ack/d_err=0, and i_rdata/d_rdata=0.
REQ-027 SHALL, on reset mid-transfer, drop s_cyc immediately with no ack or err emitted afterwards; the round-robin pointer SHALL reset to "data last granted".

Configuration
REQ-028 SHALL, when ARB_ROUND_ROBIN_EN is undefined, use fixed priority in which d_req beats i_req when both are pending in IDLE.
REQ-029 SHALL, when ARB_ROUND_ROBIN_EN is defined, keep a 1-bit last-grant pointer updated on each grant; on simultaneous requests the master not last granted wins, and a single requester always wins.

Verification
REQ-030 SHALL cover a fetch with zero wait: i_req=1, i_addr=0x100, s_ack=1 in the s_cyc cycle with s_rdata=0x3C010001 -> s_addr=0x100, s_we=0, then i_ack at cycle 2 with i_rdata=0x3C010001.
REQ-031 SHALL cover simultaneous requests without the macro: i_req and d_req (addr 0x40, we=1, sel=4'b0011, wdata=0xDEAD) raised together -> data granted first with s_sel=0011, and the fetch is granted only after RESP.
REQ-032 SHALL cover simultaneous requests with ARB_ROUND_ROBIN_EN defined: both masters requesting continuously -> grants alternate I, D, I, D after reset.
REQ-033 SHALL cover the timeout: TIMEOUT=4 and s_ack held 0 -> s_cyc stays high for 4 cycles, then d_err pulses once with d_rdata=0 and no d_ack.
REQ-034 SHALL cover flush: flush_i pulsed during BUSY_I with s_ack 3 cycles later -> the slave transfer completes, no i_ack, stallreq_if_o follows i_req.
REQ-035 SHALL cover reset mid-transfer: rst=0 asserted during BUSY_D -> s_cyc falls asynchronously, all outputs reach their reset values, and no ack or err follows release.
